// File: rtl/pc_gen.sv
// Fetch-stage PC generator: prioritised flush/redirect, one-entry pending buffer, circular RAS.
// Optional macro PC_GEN_ALIGN_CHECK_EN traps misaligned flush/redirect targets to TRAP_VEC.
module pc_gen #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              INC       = 4,
    parameter int              RAS_DEPTH = 4,
    parameter logic [XLEN-1:0] TRAP_VEC  = 'h100
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [5:0]      stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] flush_addr_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_addr_i,
    input  logic            call_i,
    input  logic            ret_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pc_valid_o,
    output logic            ras_underflow_o,
    output logic            misalign_o
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]   sp;      // next write slot; top entry is sp-1
    logic [CW-1:0]   cnt;
    logic            pend_vld, pend_flush;
    logic [XLEN-1:0] pend_addr;

    logic            advance, take, tgt_flush, bad, ras_empty, ras_we;
    logic [XLEN-1:0] seq_pc, top, tgt;
    logic [PW-1:0]   ras_wa;
    logic            unused_stall;

    assign unused_stall = ^stall_i[4:0];
    assign advance      = ~stall_i[5];
    assign seq_pc       = pc_o + XLEN'(INC);
    assign top          = ras[sp - 1'b1];
    assign ras_empty    = (cnt == '0);

    always_comb begin
        take      = 1'b1;
        tgt_flush = 1'b1;
        tgt       = flush_addr_i;
        if (!flush_i) begin
            if (pend_vld && pend_flush) begin
                tgt = pend_addr;
            end else if (redirect_i) begin
                tgt_flush = 1'b0;
                tgt       = redirect_addr_i;
            end else if (pend_vld) begin
                tgt_flush = 1'b0;
                tgt       = pend_addr;
            end else begin
                take      = 1'b0;
                tgt_flush = 1'b0;
            end
        end
    end

`ifdef PC_GEN_ALIGN_CHECK_EN
    assign bad = take && (tgt[1:0] != 2'b00);
`else
    assign bad        = 1'b0;
    assign misalign_o = 1'b0;
`endif

    // Call together with a live ret on a non-empty stack rewrites the top slot in place.
    always_comb begin
        ras_we = pc_valid_o && advance && !take && call_i;
        ras_wa = (ret_i && !ras_empty) ? sp - 1'b1 : sp;
    end

    always_ff @(posedge clk) begin
        if (ras_we) ras[ras_wa] <= seq_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_o            <= RESET_PC;
            pc_valid_o      <= 1'b0;
            ras_underflow_o <= 1'b0;
`ifdef PC_GEN_ALIGN_CHECK_EN
            misalign_o      <= 1'b0;
`endif
            pend_vld        <= 1'b0;
            pend_flush      <= 1'b0;
            pend_addr       <= '0;
            sp              <= '0;
            cnt             <= '0;
        end else begin
            pc_valid_o      <= 1'b1;
            ras_underflow_o <= 1'b0;
`ifdef PC_GEN_ALIGN_CHECK_EN
            misalign_o      <= bad && advance && pc_valid_o;
`endif
            // The first edge after reset only validates RESET_PC so it gets fetched.
            if (!pc_valid_o) begin
                pc_o <= RESET_PC;
            end else if (!advance) begin
                if (flush_i) begin
                    pend_vld   <= 1'b1;
                    pend_flush <= 1'b1;
                    pend_addr  <= flush_addr_i;
                end else if (redirect_i && !(pend_vld && pend_flush)) begin
                    pend_vld   <= 1'b1;
                    pend_flush <= 1'b0;
                    pend_addr  <= redirect_addr_i;
                end
            end else if (take) begin
                pend_vld <= 1'b0;
                pc_o     <= bad ? TRAP_VEC : tgt;
                if (tgt_flush || bad) begin
                    cnt <= '0;
                    sp  <= '0;
                end
            end else if (ret_i && !ras_empty) begin
                pc_o <= top;
                if (!call_i) begin
                    sp  <= sp - 1'b1;
                    cnt <= cnt - 1'b1;
                end
            end else begin
                pc_o            <= seq_pc;
                ras_underflow_o <= ret_i;
                if (call_i) begin
                    sp  <= sp + 1'b1;
                    cnt <= (cnt == CW'(RAS_DEPTH)) ? cnt : cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: the driver queues hand-computed expected outputs per cycle,
// a negedge monitor pops and compares them.
module tb_pc_gen;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  stall_i;
    logic        flush_i, redirect_i, call_i, ret_i;
    logic [31:0] flush_addr_i, redirect_addr_i;
    logic [31:0] pc_o;
    logic        pc_valid_o, ras_underflow_o, misalign_o;

    pc_gen dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
        .flush_i(flush_i), .flush_addr_i(flush_addr_i),
        .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
        .call_i(call_i), .ret_i(ret_i),
        .pc_o(pc_o), .pc_valid_o(pc_valid_o),
        .ras_underflow_o(ras_underflow_o), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic        vld;
        logic        uf;
        logic        mis;
        int          due;
        int          id;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   next_id = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0 && q[0].due < cyc) begin
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL step%0d: expectation never sampled (due %0d, now %0d)", e.id, e.due, cyc);
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            checks++;
            if (pc_o !== e.pc || pc_valid_o !== e.vld || ras_underflow_o !== e.uf || misalign_o !== e.mis) begin
                errors++;
                $display("FAIL step%0d: got pc=%h vld=%b uf=%b mis=%b, want pc=%h vld=%b uf=%b mis=%b",
                         e.id, pc_o, pc_valid_o, ras_underflow_o, misalign_o, e.pc, e.vld, e.uf, e.mis);
            end
        end
    end

    task automatic expect_at(input logic [31:0] pc, input logic vld, input logic uf,
                             input logic mis, input int due);
        exp_t e;
        e.pc = pc; e.vld = vld; e.uf = uf; e.mis = mis; e.due = due; e.id = next_id;
        next_id++;
        q.push_back(e);
    endtask

    // Called just after a rising edge: drive inputs, expect the state after the next edge.
    task automatic step(input logic [5:0] st, input logic fl, input logic [31:0] fa,
                        input logic rd, input logic [31:0] ra, input logic ca, input logic rt,
                        input logic [31:0] epc, input logic euf, input logic emis);
        stall_i = st; flush_i = fl; flush_addr_i = fa;
        redirect_i = rd; redirect_addr_i = ra; call_i = ca; ret_i = rt;
        expect_at(epc, 1'b1, euf, emis, cyc + 1);
        @(posedge clk); #1;
    endtask

    localparam logic [5:0] S = 6'h20;
    localparam logic [5:0] N = 6'h00;
`ifdef PC_GEN_ALIGN_CHECK_EN
    localparam logic [31:0] MIS_PC = 32'h100;
    localparam logic        MIS_P  = 1'b1;
`else
    localparam logic [31:0] MIS_PC = 32'h202;
    localparam logic        MIS_P  = 1'b0;
`endif

    initial begin
        rst_n = 1'b0;
        stall_i = 6'h00; flush_i = 0; redirect_i = 0; call_i = 0; ret_i = 0;
        flush_addr_i = '0; redirect_addr_i = '0;
        @(posedge clk); #1;
        expect_at(32'h0, 1'b0, 1'b0, 1'b0, cyc);
        @(posedge clk); #1;
        rst_n = 1'b1;
        expect_at(32'h0, 1'b0, 1'b0, 1'b0, cyc);
        //   stall fl fa        rd redirect      ca rt  exp pc        uf mis
        step(N, 0, 0,          0, 0,            0, 0,  32'h0,        0, 0);
        step(N, 0, 0,          0, 0,            0, 0,  32'h4,        0, 0);
        step(N, 0, 0,          0, 0,            0, 0,  32'h8,        0, 0);
        step(N, 0, 0,          0, 0,            0, 0,  32'hC,        0, 0);
        // redirect captured during a 3-cycle stall
        step(S, 0, 0,          1, 32'h200,      0, 0,  32'hC,        0, 0);
        step(S, 0, 0,          0, 0,            0, 0,  32'hC,        0, 0);
        step(S, 0, 0,          0, 0,            0, 0,  32'hC,        0, 0);
        step(N, 0, 0,          0, 0,            0, 0,  32'h200,      0, 0);
        step(N, 0, 0,          0, 0,            0, 0,  32'h204,      0, 0);
        // pending flush survives a later redirect and empties the RAS
        step(N, 0, 0,          0, 0,            1, 0,  32'h208,      0, 0);
        step(S, 0, 0,          1, 32'h300,      0, 0,  32'h208,      0, 0);
        step(S, 1, 32'h80,     0, 0,            0, 0,  32'h208,      0, 0);
        step(S, 0, 0,          1, 32'h400,      0, 0,  32'h208,      0, 0);
        step(N, 0, 0,          0, 0,            0, 0,  32'h80,       0, 0);
        step(N, 0, 0,          0, 0,            0, 1,  32'h84,       1, 0);
        step(N, 0, 0,          0, 0,            0, 0,  32'h88,       0, 0);
        // call/ret basics
        step(N, 1, 32'h10,     0, 0,            0, 0,  32'h10,       0, 0);
        step(N, 0, 0,          0, 0,            1, 0,  32'h14,       0, 0);
        step(N, 0, 0,          0, 0,            1, 0,  32'h18,       0, 0);
        step(N, 0, 0,          0, 0,            0, 1,  32'h18,       0, 0);
        step(N, 0, 0,          0, 0,            0, 1,  32'h14,       0, 0);
        step(N, 0, 0,          0, 0,            0, 1,  32'h18,       1, 0);
        step(N, 0, 0,          0, 0,            0, 0,  32'h1C,       0, 0);
        // depth-4 wrap: 5 calls, 5 rets
        step(N, 0, 0,          1, 32'h1000,     0, 0,  32'h1000,     0, 0);
        step(N, 0, 0,          0, 0,            1, 0,  32'h1004,     0, 0);
        step(N, 0, 0,          0, 0,            1, 0,  32'h1008,     0, 0);
        step(N, 0, 0,          0, 0,            1, 0,  32'h100C,     0, 0);
        step(N, 0, 0,          0, 0,            1, 0,  32'h1010,     0, 0);
        step(N, 0, 0,          0, 0,            1, 0,  32'h1014,     0, 0);
        step(N, 0, 0,          0, 0,            0, 1,  32'h1014,     0, 0);
        step(N, 0, 0,          0, 0,            0, 1,  32'h1010,     0, 0);
        step(N, 0, 0,          0, 0,            0, 1,  32'h100C,     0, 0);
        step(N, 0, 0,          0, 0,            0, 1,  32'h1008,     0, 0);
        step(N, 0, 0,          0, 0,            0, 1,  32'h100C,     1, 0);
        // call+ret same cycle, non-empty then empty
        step(N, 0, 0,          0, 0,            1, 0,  32'h1010,     0, 0);
        step(N, 0, 0,          0, 0,            1, 1,  32'h1010,     0, 0);
        step(N, 0, 0,          0, 0,            0, 1,  32'h1014,     0, 0);
        step(N, 0, 0,          0, 0,            1, 1,  32'h1018,     1, 0);
        step(N, 0, 0,          0, 0,            0, 1,  32'h1018,     0, 0);
        // priorities: redirect squashes ret (RAS intact), flush beats redirect
        step(N, 0, 0,          0, 0,            1, 0,  32'h101C,     0, 0);
        step(N, 0, 0,          1, 32'h2000,     0, 1,  32'h2000,     0, 0);
        step(N, 0, 0,          0, 0,            0, 1,  32'h101C,     0, 0);
        step(N, 1, 32'h3000,   1, 32'h4000,     0, 0,  32'h3000,     0, 0);
        // 32-bit wrap
        step(N, 0, 0,          1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 0, 0);
        step(N, 0, 0,          0, 0,            0, 0,  32'h0,        0, 0);
        // misaligned redirect
        step(N, 0, 0,          1, 32'h202,      0, 0,  MIS_PC,       0, MIS_P);
        step(N, 0, 0,          0, 0,            0, 0,  MIS_PC + 4,   0, 0);
        // pending redirect overwritten by a newer redirect
        step(S, 0, 0,          1, 32'h500,      0, 0,  MIS_PC + 4,   0, 0);
        step(S, 0, 0,          1, 32'h600,      0, 0,  MIS_PC + 4,   0, 0);
        step(N, 0, 0,          0, 0,            0, 0,  32'h600,      0, 0);
        // reset during a stall with a pending flush discards it
        step(S, 1, 32'h700,    0, 0,            0, 0,  32'h600,      0, 0);
        @(negedge clk); #1;
        rst_n = 1'b0; flush_i = 1'b0;
        @(posedge clk); #1;
        expect_at(32'h0, 1'b0, 1'b0, 1'b0, cyc);
        @(posedge clk); #1;
        rst_n = 1'b1; stall_i = N;
        expect_at(32'h0, 1'b0, 1'b0, 1'b0, cyc);
        step(N, 0, 0,          0, 0,            0, 0,  32'h0,        0, 0);
        step(N, 0, 0,          0, 0,            0, 0,  32'h4,        0, 0);
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Next-generation program-counter generator for the fetch stage.
- Replaces the fixed 32-bit "PC+4 or jump" register with a parametrised unit that provides:
  - prioritised redirect sources (exception flush, branch/jump);
  - a pending-redirect buffer, so redirects arriving during a stall are not lost;
  - a return-address stack (RAS) that predicts return targets.
- Drives the instruction-memory address and the IF-stage PC.

Parameters:
- XLEN, 32, PC width in bits.
- RESET_PC, 32'h0000_0000, pc_o value during and after reset.
- INC, 4, sequential increment in bytes.
- RAS_DEPTH, 4, return-address stack entries; power of 2, at least 2.
- TRAP_VEC, 32'h0000_0100, target used on a misaligned redirect (only with ALIGN_CHECK_EN).

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall_i  in  6  pipeline stall bus; bit 5 holds the PC stage.
- flush_i  in  1  exception/flush request; highest priority.
- flush_addr_i  in  XLEN  flush target.
- redirect_i  in  1  resolved branch/jump taken.
- redirect_addr_i  in  XLEN  branch/jump target.
- call_i  in  1  instruction at pc_o is a call; push return address.
- ret_i  in  1  instruction at pc_o is a return; predict from RAS.
- pc_o  out  XLEN  current fetch PC.
- pc_valid_o  out  1  pc_o holds a fetchable address.
- ras_underflow_o  out  1  one-cycle pulse: ret_i with empty RAS.
- misalign_o  out  1  one-cycle pulse: misaligned redirect trapped (ALIGN_CHECK_EN only).

Behaviour:
- Reset (async, rst_n=0):
  - pc_o=RESET_PC, pc_valid_o=0, ras_underflow_o=0, misalign_o=0.
  - Pending buffer empty; RAS count=0, top pointer=0.
- pc_valid_o rises on the first clk edge after rst_n deasserts and stays 1 until the next reset.
- Advance cycle: stall_i[5]=0. pc_o updates at that edge (1-cycle latency from any input). Next-PC priority:
  1. flush_i live
  2. pending flush
  3. redirect_i live
  4. pending redirect
  5. ret_i with RAS non-empty (target = RAS top)
  6. pc_o+INC
- Hold cycle: stall_i[5]=1. pc_o holds. flush_i and redirect_i are captured into the one-entry pending buffer, which stores kind and address:
  - a flush overwrites any pending entry;
  - a redirect overwrites a pending redirect but never a pending flush;
  - call_i and ret_i are ignored.
- Pending buffer is cleared on the advance cycle that consumes it, or is superseded by a live flush/redirect of equal or higher priority.
- call_i/ret_i act only on advance cycles with no live or pending flush/redirect. Those instructions are squashed otherwise.
- RAS is circular:
  - call pushes pc_o+INC; count saturates at RAS_DEPTH.
  - Pushing when full overwrites the oldest entry (wrap).
  - ret with count>0: next pc = top, then pop.
  - ret with count=0: next pc = pc_o+INC, ras_underflow_o=1 for that cycle.
  - call and ret in the same cycle: next pc = old top, top entry replaced by pc_o+INC, count unchanged. If the RAS was empty, follow the underflow rule and then push.
- Any applied flush (live or pending) empties the RAS (count=0). A redirect does not modify the RAS.
- Arithmetic: pc_o+INC computed modulo 2^XLEN; 0xFFFF_FFFC+4 wraps to 0.
- Reset mid-stall or with a pending entry discards all state immediately.

Optional Feature:
- Macro: PC_GEN_ALIGN_CHECK_EN.
- Defined:
  - An applied flush/redirect target with addr[1:0]!=0 sets the next pc to TRAP_VEC instead.
  - misalign_o pulses 1 in the cycle pc_o takes TRAP_VEC.
  - The RAS is emptied, as for a flush.
- Undefined:
  - Targets are used unmodified.
  - misalign_o tied 0; the port still exists.

Test Plan:
- Reset release, no inputs, stall_i=0 → pc_o sequence 0x0, 0x4, 0x8, 0xC; pc_valid_o=1 from the first edge after release.
- stall_i[5]=1 for 3 cycles with redirect_i=1, addr=0x200 in cycle 1 only → pc_o holds through the stall; first unstalled edge gives pc_o=0x200; following edge gives 0x204.
- During a stall: redirect 0x300, then flush 0x80, then redirect 0x400 → after release pc_o=0x80 (flush retained); RAS empty.
- pc_o=0x10 call → pc_o=0x14 call → ret → pc_o=0x18; next ret → pc_o=0x14; a third ret → sequential PC, ras_underflow_o=1 for one cycle.
- RAS_DEPTH=4: 5 nested calls, then 5 rets → first 4 rets return to the last 4 return addresses (newest first); the 5th ret underflows.
- With PC_GEN_ALIGN_CHECK_EN: redirect_i addr=0x202 → pc_o=TRAP_VEC (0x100), misalign_o=1 for one cycle. Without the macro → pc_o=0x202, misalign_o=0.
